// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN serial output path: frame width, deserialiser
// state encoding and a width helper for counters.
package rnn_pkg;

   localparam int unsigned RNN_DATA_W     = 8;
   localparam int unsigned RNN_FRAME_BITS = RNN_DATA_W;

   typedef enum logic [1:0] {IDLE, REQ, RECV, BACKOFF} deser_state_e;

   // Bits needed to index n positions, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rnn_sync_fifo.sv
// Synchronous FIFO with registered count and flags; head word is read from the
// register array at the read pointer.
module rnn_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             r_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;

   // A push while full is accepted only when the same edge frees a slot.
   always_comb begin
      w_do_pop    = i_pop && !r_empty;
      w_do_push   = i_push && (!r_full || w_do_pop);
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem    <= '{default: '0};
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CW'(DEPTH));
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;

endmodule

// File: rtl/rnn_out_deser.sv
// Requests bit-serial frames from the RNN, deserialises them LSB first and
// buffers the words for a valid/ready consumer, flagging timeouts and stray ACKs.
module rnn_out_deser
   import rnn_pkg::*;
#(
   parameter int unsigned DATA_W     = RNN_FRAME_BITS,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                            CLK,
   input  logic                            RSTB,
   input  logic                            EN,
   output logic                            OUT_REQ,
   input  logic                            OUT_ACK,
   input  logic                            OUT_DATA,
   output logic [DATA_W-1:0]               M_DATA,
   output logic                            M_VALID,
   input  logic                            M_READY,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_CNT,
   output logic                            BUSY,
   output logic                            TIMEOUT_ERR,
   output logic                            PROTO_ERR,
   input  logic                            CLR_ERR
);

   localparam int unsigned       CNT_W    = cnt_width(DATA_W);
   localparam int unsigned       TO_W     = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT);

   deser_state_e      r_state;
   deser_state_e      w_next;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_word;
   logic [CNT_W-1:0]  r_bitcnt;
   logic [TO_W-1:0]   r_to_cnt;
   logic [TO_W-1:0]   w_to_inc;
   logic              r_out_req;
   logic              r_busy;
   logic              r_to_err;
   logic              r_proto_err;
   logic              w_push;
   logic              w_to_hit;
   logic              w_proto_hit;
   logic              w_fifo_full;
   logic              w_fifo_empty;

   // An ACK on the edge where the count would reach the limit takes priority.
   always_comb begin
      w_next      = r_state;
      w_push      = 1'b0;
      w_to_hit    = 1'b0;
      w_proto_hit = 1'b0;
      w_to_inc    = r_to_cnt + TO_W'(1);
      w_word      = r_shift;
      w_word[DATA_W-1] = OUT_DATA;
      case (r_state)
         IDLE: begin
            if (EN && !w_fifo_full) w_next = REQ;
         end
         REQ: begin
            if (OUT_ACK) begin
               w_next = RECV;
            end else if ((TIMEOUT != 0) && (w_to_inc == TO_LIMIT)) begin
               w_to_hit = 1'b1;
               w_next   = BACKOFF;
            end
         end
         RECV: begin
            w_proto_hit = OUT_ACK;
            if (r_bitcnt == LAST_BIT) begin
               w_push = 1'b1;
               w_next = IDLE;
            end
         end
         BACKOFF: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RSTB) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_to_cnt    <= '0;
         r_out_req   <= 1'b0;
         r_busy      <= 1'b0;
         r_to_err    <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_out_req   <= (w_next == REQ);
         r_busy      <= (w_next != IDLE);
         r_to_err    <= (r_to_err & ~CLR_ERR) | w_to_hit;
         r_proto_err <= (r_proto_err & ~CLR_ERR) | w_proto_hit;
         case (r_state)
            REQ: begin
               if (OUT_ACK) begin
                  r_shift[0] <= OUT_DATA;
                  r_bitcnt   <= CNT_W'(1);
                  r_to_cnt   <= '0;
               end else begin
                  r_to_cnt <= w_to_hit ? '0 : w_to_inc;
               end
            end
            RECV: begin
               r_shift[r_bitcnt] <= OUT_DATA;
               r_bitcnt <= (r_bitcnt == LAST_BIT) ? '0 : r_bitcnt + CNT_W'(1);
            end
            default: r_to_cnt <= '0;
         endcase
      end
   end

   rnn_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst   (RSTB),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (M_READY),
      .o_data  (M_DATA),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (FIFO_CNT)
   );

   assign OUT_REQ     = r_out_req;
   assign M_VALID     = ~w_fifo_empty;
   assign BUSY        = r_busy;
   assign TIMEOUT_ERR = r_to_err;
   assign PROTO_ERR   = r_proto_err;

endmodule
